// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// one iteration per clock, results delivered to HI/LO with a one-cycle Done pulse.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MultStart,
   input  logic             DivStart,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StMult, StDiv, StFinish} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH+1:0]   acc_q, acc_d;
   logic [WIDTH:0]       mcand_q, mcand_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;
   logic                 qneg_q, qneg_d;
   logic                 rneg_q, rneg_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 divzero_q, divzero_d;

   logic [WIDTH:0]       upper;
   logic [WIDTH:0]       upper_sum;
   logic [2*WIDTH+1:0]   acc_step;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     rem_nx;
   logic [WIDTH-1:0]     quo_nx;
   logic [WIDTH-1:0]     a_abs;
   logic [WIDTH-1:0]     b_abs;

   // Booth step: the upper half carries one guard bit so that subtracting the most negative
   // multiplicand cannot overflow before the arithmetic shift.
   always_comb begin
      upper = acc_q[2*WIDTH+1:WIDTH+1];
      unique case (acc_q[1:0])
         2'b01:   upper_sum = upper + mcand_q;
         2'b10:   upper_sum = upper - mcand_q;
         default: upper_sum = upper;
      endcase
      acc_step = $signed({upper_sum, acc_q[WIDTH:0]}) >>> 1;
   end

   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvsr_q};
      rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      a_abs  = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
      b_abs  = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      divzero_d = 1'b0;

      unique case (state_q)
         StIdle, StFinish: begin
            state_d = StIdle;
            if (MultStart) begin
               acc_d   = {{(WIDTH+1){1'b0}}, A, 1'b0};
               mcand_d = {B[WIDTH-1], B};
               cnt_d   = '0;
               state_d = StMult;
            end else if (DivStart) begin
               if (B != '0) begin
                  quo_d   = a_abs;
                  rem_d   = '0;
                  dvsr_d  = b_abs;
                  qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
                  rneg_d  = A[WIDTH-1];
                  cnt_d   = '0;
                  state_d = StDiv;
               end else begin
                  divzero_d = 1'b1;
                  state_d   = StFinish;
               end
            end
         end
         StMult: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               hi_d    = acc_step[2*WIDTH:WIDTH+1];
               lo_d    = acc_step[WIDTH:1];
               cnt_d   = '0;
               state_d = StFinish;
            end
         end
         StDiv: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               lo_d    = qneg_q ? (WIDTH'(0) - quo_nx) : quo_nx;
               hi_d    = rneg_q ? (WIDTH'(0) - rem_nx) : rem_nx;
               cnt_d   = '0;
               state_d = StFinish;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StMult) || (state_d == StDiv);
      done_d = (state_d == StFinish);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = divzero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner
// sequences, and randomized operations checked against a plain-arithmetic model.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clk;
   logic          reset;
   logic          MultStart;
   logic          DivStart;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [W-1:0]  HI;
   logic [W-1:0]  LO;
   logic          Busy;
   logic          Done;
   logic          DivZero;

   int tests;
   int fails;
   logic [W-1:0] model_hi;
   logic [W-1:0] model_lo;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .MultStart (MultStart),
      .DivStart  (DivStart),
      .A         (A),
      .B         (B),
      .HI        (HI),
      .LO        (LO),
      .Busy      (Busy),
      .Done      (Done),
      .DivZero   (DivZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          ms;
      bit          ds;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      bit          dz;
      bit          poke;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Reference: signed products and C-style truncating division on 64-bit integers.
   function automatic void model_op(input bit ms, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output bit dz);
      longint p, sa, sb, q, r;
      dz = 1'b0;
      hi = model_hi;
      lo = model_lo;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (ms) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         dz = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   // Called just after the accepting edge; watches negedges until Done or the bound expires.
   task automatic wait_done(input bit hold, input bit poke, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int k = 1; k <= W + 8; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) begin
            MultStart = 1'b0;
            DivStart  = 1'b0;
            A         = $urandom;
            B         = $urandom;
         end
         if (poke && k == 8) begin
            MultStart = 1'b1;
            DivStart  = 1'b1;
            A         = $urandom;
            B         = $urandom;
         end
         if (poke && k == 9) begin
            MultStart = 1'b0;
            DivStart  = 1'b0;
         end
         if (Busy) bcnt++;
         if (Done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input bit ms, input bit ds, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input bit edz,
                         input bit hold, input bit poke, input string tag);
      int lat, bcnt;
      @(negedge clk);
      MultStart = ms;
      DivStart  = ds;
      A         = a;
      B         = b;
      @(posedge clk);
      wait_done(hold, poke, lat, bcnt);
      check({tag, " latency"}, 64'(lat), edz ? 64'd1 : 64'(W + 1));
      check({tag, " busy cycles"}, 64'(bcnt), edz ? 64'd0 : 64'(W));
      check({tag, " HI"}, 64'(HI), 64'(ehi));
      check({tag, " LO"}, 64'(LO), 64'(elo));
      check({tag, " DivZero"}, 64'(DivZero), 64'(edz));
      model_hi = ehi;
      model_lo = elo;
      if (!hold) begin
         @(negedge clk);
         check({tag, " done one cycle"}, {61'd0, Done, DivZero, Busy}, 64'd0);
         check({tag, " HI/LO held"}, {HI, LO}, {ehi, elo});
      end
   endtask

   initial begin
      logic [31:0] ehi, elo, ra, rb;
      bit          edz, rms, rds, rpoke;
      int          lat, bcnt, dcnt;

      tests     = 0;
      fails     = 0;
      model_hi  = '0;
      model_lo  = '0;
      reset     = 1'b0;
      MultStart = 1'b0;
      DivStart  = 1'b0;
      A         = '0;
      B         = '0;

      vecs[0]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h3FFFFFFF, 32'h00000001, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'h00000001, 32'h00000005, 32'h00000001, 32'h00000000, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset HI/LO", {HI, LO}, 64'd0);
      check("reset flags", {61'd0, Busy, Done, DivZero}, 64'd0);

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].ms, vecs[i].ds, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                vecs[i].dz, 1'b0, vecs[i].poke, $sformatf("vec%0d", i));
      end

      // Start held through FINISH is accepted on the edge leaving it.
      run_op(1'b1, 1'b0, 32'h00001234, 32'hFFFF0000, 32'hFFFFFFFF, 32'hEDCC0000, 1'b0, 1'b1,
             1'b0, "hold first");
      @(posedge clk);
      wait_done(1'b0, 1'b0, lat, bcnt);
      check("hold second latency", 64'(lat), 64'(W + 1));
      check("hold second busy", 64'(bcnt), 64'(W));
      check("hold second HI/LO", {HI, LO}, {32'hFFFFFFFF, 32'hEDCC0000});
      @(negedge clk);
      check("hold second done one cycle", {63'd0, Done}, 64'd0);

      // Reset pulse mid-multiply aborts at once and produces no Done.
      @(negedge clk);
      MultStart = 1'b1;
      A         = 32'd3;
      B         = 32'd5;
      @(negedge clk);
      MultStart = 1'b0;
      repeat (8) @(negedge clk);
      check("pre-abort busy", {63'd0, Busy}, 64'd1);
      reset = 1'b0;
      #1;
      check("abort HI/LO", {HI, LO}, 64'd0);
      check("abort flags", {61'd0, Busy, Done, DivZero}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      dcnt  = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         if (Done || Busy) dcnt++;
      end
      check("no done after abort", 64'(dcnt), 64'd0);
      model_hi = '0;
      model_lo = '0;
      run_op(1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, 1'b0, "post-abort");

      for (int i = 0; i < 30; i++) begin
         rms   = ($urandom_range(0, 2) == 0);
         rds   = !rms || ($urandom_range(0, 3) == 0);
         ra    = $urandom;
         rb    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
         rpoke = ($urandom_range(0, 3) == 0);
         model_op(rms, ra, rb, ehi, elo, edz);
         run_op(rms, rds, ra, rb, ehi, elo, edz, 1'b0, rpoke, $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
